seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: accepts a PAT_W-bit word over a valid/ready handshake and

---
 rtl/seq_pattern_tx.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a word, shifts it MSB-first (in_rep+1) times with idle gaps.
// Optional even-parity bit per repetition when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
  parameter int PAT_W   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAT_W-1:0] in_data,
  input  logic [REP_W-1:0] in_rep,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             frame_done
);

`ifdef SEQ_TX_PARITY_EN
  localparam int NB = PAT_W + 1;
`else
  localparam int NB = PAT_W;
`endif
  localparam int IW = $clog2(NB);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NB - 1);
  localparam logic [GW-1:0] GAP_TOP = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [PAT_W-1:0] shifted;
  logic             bit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      rep_q        <= '0;
      gap_q        <= '0;
      ser_out_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      rep_q        <= rep_d;
      gap_q        <= gap_d;
      ser_out_q    <= ser_out_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          word_d  = in_data;
          rep_d   = in_rep;
          idx_d   = IDX_TOP;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gap_d   = '0;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
          if (GAP_CYC > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_TOP;
          end else begin
            idx_d = IDX_TOP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gap_d   = '0;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else begin
          state_d = S_SHIFT;
          idx_d   = IDX_TOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the bit being sent.
  always_comb begin
    ser_en_d     = (state_d == S_SHIFT);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = ser_en_d && (idx_d == '0) && (rep_d == '0);
    shifted      = '0;
`ifdef SEQ_TX_PARITY_EN
    if (idx_d == '0) begin
      bit_d = ^word_d;
    end else begin
      shifted = word_d >> (idx_d - IW'(1));
      bit_d   = shifted[0];
    end
`else
    shifted = word_d >> idx_d;
    bit_d   = shifted[0];
`endif
    ser_out_d = ser_en_d & bit_d;
  end

  assign in_ready   = (state_q == S_IDLE);
  assign ser_out    = ser_out_q;
  assign ser_en     = ser_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random frames against a per-cycle expected-stream model.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va = 1'b0, va0 = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_rep = '0;
  logic       abort = 1'b0;
  logic       rdy, so, en, bsy, fd;
  logic       rdy0, so0, en0, bsy0, fd0;
  int         checks = 0;
  int         errors = 0;

  seq_pattern_tx #(.PAT_W(8), .REP_W(4), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy), .in_data(in_data),
    .in_rep(in_rep), .abort(abort), .ser_out(so), .ser_en(en), .busy(bsy),
    .frame_done(fd));

  seq_pattern_tx #(.PAT_W(8), .REP_W(4), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(va0), .in_ready(rdy0), .in_data(in_data),
    .in_rep(in_rep), .abort(abort), .ser_out(so0), .ser_en(en0), .busy(bsy0),
    .frame_done(fd0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, busy, ser_en, ser_out, frame_done} of the selected instance
  function automatic logic [4:0] obs(input bit g0);
    return g0 ? {rdy0, bsy0, en0, so0, fd0} : {rdy, bsy, en, so, fd};
  endfunction

  // Expected per-cycle {busy, ser_en, ser_out, frame_done}, built from the frame rules.
  task automatic run_frame(input bit g0, input logic [7:0] d, input logic [3:0] r,
                           input int abort_cyc, input int intr_cyc, input bit hs_abort);
    logic [3:0] q[$];
    int gap;
    gap = g0 ? 0 : 2;
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = 7; i >= 0; i--) q.push_back({2'b11, d[i], 1'b0});
      if (PAR) q.push_back({2'b11, ^d, 1'b0});
      if (k < int'(r)) for (int j = 0; j < gap; j++) q.push_back(4'b1000);
    end
    q[q.size()-1][0] = 1'b1;
    in_data = d;
    in_rep  = r;
    abort   = hs_abort;
    if (g0) va0 = 1'b1; else va = 1'b1;
    chk("hs_ready", obs(g0)[4], 1'b1);
    @(posedge clk); #1;
    va = 1'b0; va0 = 1'b0; abort = 1'b0;
    for (int c = 1; c <= q.size(); c++) begin
      if (c == intr_cyc) begin
        in_data = 8'hFF;
        if (g0) va0 = 1'b1; else va = 1'b1;
      end
      if (c == abort_cyc) abort = 1'b1;
      @(negedge clk);
      chk($sformatf("cyc%0d_d%0h", c, d), obs(g0), {1'b0, q[c-1]});
      @(posedge clk); #1;
      va = 1'b0; va0 = 1'b0;
      if (c == abort_cyc) begin
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", obs(g0), 5'b10000);
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("end_d%0h", d), obs(g0), 5'b10000);
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_dut", obs(1'b0), 5'b10000);
    chk("rst_dut0", obs(1'b1), 5'b10000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_frame(1'b0, 8'hA5, 4'd0, -1, -1, 1'b0);
    run_frame(1'b0, 8'hC3, 4'd2, -1, -1, 1'b0);
    run_frame(1'b1, 8'h81, 4'd1, -1, -1, 1'b0);
    run_frame(1'b0, 8'hA5, 4'd0, -1, 4, 1'b0);
    run_frame(1'b0, 8'hFF, 4'd0, -1, -1, 1'b0);
    run_frame(1'b0, 8'hA5, 4'd0, 5, -1, 1'b0);
    run_frame(1'b0, 8'h3C, 4'd2, 10, -1, 1'b0);
    run_frame(1'b1, 8'h5A, 4'd2, 12, -1, 1'b0);
    run_frame(1'b0, 8'h96, 4'd1, -1, -1, 1'b1);
    run_frame(1'b0, 8'h07, 4'd0, -1, -1, 1'b0);
    run_frame(1'b0, 8'h03, 4'd1, -1, -1, 1'b0);

    // Async reset while in the gap between repetitions.
    in_data = 8'hE1; in_rep = 4'd1; va = 1'b1;
    @(posedge clk); #1; va = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("gap_before_rst", obs(1'b0), 5'b01000);
    rst = 1'b1;
    #1;
    chk("rst_mid_gap", obs(1'b0), 5'b10000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 30; n++) begin
      run_frame(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1,
                1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
